// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
//
// Oversampling UART receiver that runs directly on the system clock. The rx line is
// synchronised, a start edge is qualified at the middle of the start bit, and the
// data, optional parity and one or two stop bits are then sampled once per bit
// period. One parallel word is presented per frame, together with parity and
// framing error flags.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   en_i           receiver enable; low aborts any frame in progress
//   rx_i           asynchronous serial line, idle high
//   baud_div_i     clk_i cycles per oversample tick (0 behaves as 1)
//   data_size_i    data bits, clamped to 5..9
//   parity_size_i  1 = parity bit present
//   parity_type_i  1 = odd parity, 0 = even parity
//   stop_size_i    0/1 = one stop bit, 2/3 = two stop bits
//   data_o         received word, right-justified, unused upper bits 0
//   rx_valid_o     one-cycle pulse when a frame completes
//   parity_err_o   parity mismatch, qualified by rx_valid_o
//   frame_err_o    a stop bit sampled low, qualified by rx_valid_o
//   busy_o         receiver is inside a frame

module uart_rx_sampler #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 rx_i,
  input  logic [DIV_WIDTH-1:0] baud_div_i,
  input  logic [3:0]           data_size_i,
  input  logic                 parity_size_i,
  input  logic                 parity_type_i,
  input  logic [1:0]           stop_size_i,
  output logic [8:0]           data_o,
  output logic                 rx_valid_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 busy_o
);

  localparam int unsigned ScWidth = $clog2(OVERSAMPLE);
  localparam logic [ScWidth-1:0] ScMid = ScWidth'(OVERSAMPLE / 2 - 1);
  localparam logic [ScWidth-1:0] ScEnd = ScWidth'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic rx_meta_d, rx_meta_q;
  logic rx_s_d, rx_s_q;

  always_comb begin
    rx_meta_d = rx_i;
    rx_s_d    = rx_meta_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Oversample tick generator
  // ---------------------------------------------------------------------------
  logic [DIV_WIDTH-1:0] div_cnt_d, div_cnt_q;
  logic [DIV_WIDTH-1:0] div_top;
  logic                 tick;

  always_comb begin
    div_top = (baud_div_i == '0) ? '0 : baud_div_i - DIV_WIDTH'(1);
    // >= rather than == so a divisor lowered on the fly cannot strand the counter
    tick    = en_i && (div_cnt_q >= div_top);
    if (!en_i || tick) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame configuration clamp
  // ---------------------------------------------------------------------------
  logic [3:0] data_bits;

  always_comb begin
    if (data_size_i < 4'd5) begin
      data_bits = 4'd5;
    end else if (data_size_i > 4'd9) begin
      data_bits = 4'd9;
    end else begin
      data_bits = data_size_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_e               state_d, state_q;
  logic [ScWidth-1:0]   sc_d, sc_q;
  logic [3:0]           bit_idx_d, bit_idx_q;
  logic                 stop_idx_d, stop_idx_q;
  logic                 armed_d, armed_q;
  logic [3:0]           nbits_d, nbits_q;
  logic                 par_en_d, par_en_q;
  logic                 par_odd_d, par_odd_q;
  logic                 two_stop_d, two_stop_q;
  logic [8:0]           shift_d, shift_q;
  logic                 perr_d, perr_q;
  logic                 ferr_d, ferr_q;
  logic [8:0]           data_out_d, data_out_q;
  logic                 valid_d, valid_q;
  logic                 perr_out_d, perr_out_q;
  logic                 ferr_out_d, ferr_out_q;

  always_comb begin
    state_d    = state_q;
    sc_d       = sc_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    armed_d    = armed_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    two_stop_d = two_stop_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    data_out_d = data_out_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    valid_d    = 1'b0;

    if (!en_i) begin
      // Abort: discard the partial frame and require the line to go high again
      state_d = StIdle;
      sc_d    = '0;
      armed_d = 1'b0;
    end else if (tick) begin
      // Any idle-level sample re-arms start detection; clears below take priority
      if (rx_s_q) begin
        armed_d = 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (armed_q && !rx_s_q) begin
            state_d    = StStart;
            sc_d       = '0;
            armed_d    = 1'b0;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            nbits_d    = data_bits;
            par_en_d   = parity_size_i;
            par_odd_d  = parity_type_i;
            two_stop_d = (stop_size_i >= 2'd2);
            shift_d    = '0;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
          end
        end

        StStart: begin
          if (sc_q == ScMid) begin
            sc_d      = '0;
            bit_idx_d = '0;
            // Line back high at mid-bit means the edge was a glitch
            state_d   = rx_s_q ? StIdle : StData;
          end else begin
            sc_d = sc_q + ScWidth'(1);
          end
        end

        StData: begin
          if (sc_q == ScEnd) begin
            sc_d              = '0;
            shift_d[bit_idx_q] = rx_s_q;
            if (bit_idx_q == nbits_q - 4'd1) begin
              state_d = par_en_q ? StParity : StStop;
            end else begin
              bit_idx_d = bit_idx_q + 4'd1;
            end
          end else begin
            sc_d = sc_q + ScWidth'(1);
          end
        end

        StParity: begin
          if (sc_q == ScEnd) begin
            sc_d       = '0;
            stop_idx_d = 1'b0;
            // Unused upper shift bits are zero, so the full-width XOR is exact
            perr_d     = rx_s_q != ((^shift_q) ^ par_odd_q);
            state_d    = StStop;
          end else begin
            sc_d = sc_q + ScWidth'(1);
          end
        end

        StStop: begin
          if (sc_q == ScEnd) begin
            sc_d = '0;
            if (!rx_s_q) begin
              ferr_d = 1'b1;
            end
            if (two_stop_q && !stop_idx_q) begin
              stop_idx_d = 1'b1;
            end else begin
              state_d    = StIdle;
              valid_d    = 1'b1;
              data_out_d = shift_q;
              perr_out_d = perr_q;
              ferr_out_d = ferr_q | ~rx_s_q;
              // A break must not retrigger until the line has been seen high
              if (ferr_q | ~rx_s_q) begin
                armed_d = 1'b0;
              end
            end
          end else begin
            sc_d = sc_q + ScWidth'(1);
          end
        end

        default: begin
          state_d = StIdle;
          sc_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      sc_q       <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      armed_q    <= 1'b0;
      nbits_q    <= 4'd8;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sc_q       <= sc_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      armed_q    <= armed_d;
      nbits_q    <= nbits_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      two_stop_q <= two_stop_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
    end
  end

  assign data_o       = data_out_q;
  assign rx_valid_o   = valid_q;
  assign parity_err_o = perr_out_q;
  assign frame_err_o  = ferr_out_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: frames are driven bit by bit on rx_i and the
// expected word/flags are queued; a monitor pops and compares on every rx_valid_o.

module tb_uart_rx_sampler;

  localparam int BitCycles = 4 * 16;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       en_i;
  logic       rx_i;
  logic [15:0] baud_div_i;
  logic [3:0] data_size_i;
  logic       parity_size_i;
  logic       parity_type_i;
  logic [1:0] stop_size_i;
  logic [8:0] data_o;
  logic       rx_valid_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       busy_o;

  always #5 clk_i = ~clk_i;

  uart_rx_sampler #(
    .OVERSAMPLE(16),
    .DIV_WIDTH (16)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .rx_i         (rx_i),
    .baud_div_i   (baud_div_i),
    .data_size_i  (data_size_i),
    .parity_size_i(parity_size_i),
    .parity_type_i(parity_type_i),
    .stop_size_i  (stop_size_i),
    .data_o       (data_o),
    .rx_valid_o   (rx_valid_o),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .busy_o       (busy_o)
  );

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total  = 0;
  int   bad    = 0;
  int   pulses = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk_i) begin
    if (rst_ni && rx_valid_o) begin
      pulses++;
      total++;
      assert (sb.size() != 0)
      else begin
        bad++;
        $error("FAIL unexpected_pulse: observed data=0x%0h expected no pulse", data_o);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("rx_data", {23'd0, data_o}, {23'd0, mon_e.data});
        check("rx_parity_err", {31'd0, parity_err_o}, {31'd0, mon_e.perr});
        check("rx_frame_err", {31'd0, frame_err_o}, {31'd0, mon_e.ferr});
      end
    end
  end

  task automatic hold_line(input logic v, input int cycles);
    rx_i = v;
    repeat (cycles) @(negedge clk_i);
  endtask

  // Drives one frame using the current parity_type_i; optionally queues the expectation
  task automatic send_frame(input logic [8:0] d, input int nbits, input bit par_en,
                            input logic par_bit, input int nstop, input logic stop_val,
                            input bit expect_pulse);
    logic [8:0] masked;
    exp_t       e;
    masked = '0;
    for (int i = 0; i < 9; i++) begin
      if (i < nbits) masked[i] = d[i];
    end
    if (expect_pulse) begin
      e.data = masked;
      e.perr = par_en && (par_bit != ((^masked) ^ parity_type_i));
      e.ferr = (stop_val == 1'b0);
      sb.push_back(e);
    end
    hold_line(1'b0, BitCycles);
    for (int i = 0; i < nbits; i++) hold_line(masked[i], BitCycles);
    if (par_en) hold_line(par_bit, BitCycles);
    for (int i = 0; i < nstop; i++) hold_line(stop_val, BitCycles);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 4000) begin
      @(negedge clk_i);
      n++;
    end
    check(tag, sb.size(), 0);
  endtask

  int p0;

  initial begin
    rst_ni        = 1'b0;
    en_i          = 1'b1;
    rx_i          = 1'b1;
    baud_div_i    = 16'd4;
    data_size_i   = 4'd8;
    parity_size_i = 1'b0;
    parity_type_i = 1'b0;
    stop_size_i   = 2'd0;
    repeat (3) @(negedge clk_i);
    check("reset_data", {23'd0, data_o}, 0);
    check("reset_valid", {31'd0, rx_valid_o}, 0);
    check("reset_perr", {31'd0, parity_err_o}, 0);
    check("reset_ferr", {31'd0, frame_err_o}, 0);
    check("reset_busy", {31'd0, busy_o}, 0);
    rst_ni = 1'b1;
    hold_line(1'b1, 2 * BitCycles);

    // 8N1 0xA5
    send_frame(9'h0A5, 8, 0, 1'b0, 1, 1'b1, 1);
    wait_drain("drain_8n1");
    hold_line(1'b1, 8);
    check("busy_after_8n1", {31'd0, busy_o}, 0);
    check("pulses_8n1", pulses, 1);

    // 7E1 0x55, wrong then right parity
    data_size_i   = 4'd7;
    parity_size_i = 1'b1;
    parity_type_i = 1'b0;
    send_frame(9'h055, 7, 1, 1'b1, 1, 1'b1, 1);
    hold_line(1'b1, BitCycles);
    send_frame(9'h055, 7, 1, 1'b0, 1, 1'b1, 1);
    wait_drain("drain_7e1");
    hold_line(1'b1, BitCycles);
    check("hold_data_7e1", {23'd0, data_o}, 32'h055);

    // Start glitch of 3 ticks
    data_size_i   = 4'd8;
    parity_size_i = 1'b0;
    p0 = pulses;
    hold_line(1'b0, 12);
    check("glitch_busy_high", {31'd0, busy_o}, 1);
    hold_line(1'b1, 60);
    check("glitch_busy_low", {31'd0, busy_o}, 0);
    hold_line(1'b1, BitCycles);
    check("glitch_no_pulse", pulses, p0);

    // Break: line low for 30 bit times
    p0 = pulses;
    send_frame(9'h000, 8, 0, 1'b0, 1, 1'b0, 1);
    hold_line(1'b0, 20 * BitCycles);
    check("break_one_pulse", pulses, p0 + 1);
    check("break_busy", {31'd0, busy_o}, 0);
    hold_line(1'b1, 2 * BitCycles);
    send_frame(9'h03C, 8, 0, 1'b0, 1, 1'b1, 1);
    wait_drain("drain_after_break");
    hold_line(1'b1, BitCycles);
    check("after_break_pulses", pulses, p0 + 2);

    // en_i dropped during data bit 3 of 0x0F
    p0 = pulses;
    hold_line(1'b0, BitCycles);
    for (int i = 0; i < 3; i++) hold_line(1'b1, BitCycles);
    hold_line(1'b1, BitCycles / 2);
    check("abort_busy_before", {31'd0, busy_o}, 1);
    en_i = 1'b0;
    @(negedge clk_i);
    check("abort_busy_after", {31'd0, busy_o}, 0);
    hold_line(1'b1, 2 * BitCycles);
    en_i = 1'b1;
    hold_line(1'b1, BitCycles);
    check("abort_no_pulse", pulses, p0);

    // Asynchronous reset mid-frame
    hold_line(1'b0, BitCycles);
    hold_line(1'b1, BitCycles);
    hold_line(1'b0, BitCycles / 2);
    rst_ni = 1'b0;
    #1;
    check("rst_mid_data", {23'd0, data_o}, 0);
    check("rst_mid_busy", {31'd0, busy_o}, 0);
    check("rst_mid_valid", {31'd0, rx_valid_o}, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    hold_line(1'b1, 2 * BitCycles);
    send_frame(9'h05A, 8, 0, 1'b0, 1, 1'b1, 1);
    wait_drain("drain_after_reset");
    hold_line(1'b1, BitCycles);
    check("after_reset_pulses", pulses, p0 + 1);

    // 9O2 back-to-back
    p0 = pulses;
    data_size_i   = 4'd9;
    parity_size_i = 1'b1;
    parity_type_i = 1'b1;
    stop_size_i   = 2'd2;
    send_frame(9'h1FF, 9, 1, 1'b0, 2, 1'b1, 1);
    send_frame(9'h100, 9, 1, 1'b0, 2, 1'b1, 1);
    wait_drain("drain_9o2");
    hold_line(1'b1, BitCycles);
    check("b2b_pulses", pulses, p0 + 2);
    check("b2b_last_data", {23'd0, data_o}, 32'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
